// File: rtl/axi_bram_log_reader_pkg.sv
// -----------------------------------------------------------------------------
// axi_log_pkg
// Shared definitions for the logging-BRAM read-out path:
//   - bit offsets of the fields inside one 96-bit address-event record
//   - number of stream words per record
//   - BRAM capacity (entries) as a function of the serial BRAM count
//   - drain FSM state encoding
// -----------------------------------------------------------------------------
package axi_log_pkg;

    // Record layout, LSB first: {timestamp, address, id/len}
    localparam int ID_LOW              = 0;
    localparam int LEN_LOW             = 16;
    localparam int ADDR_LOW            = 32;
    localparam int TS_LOW              = 64;
    localparam int LOG_WORDS_PER_ENTRY = 3;

    // Each serial BRAM contributes 1024 entries.
    function automatic int log_cap(input int num_ser_brams);
        return 1024 * num_ser_brams;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        SEND,
        DONE
    } state_e;

endpackage

// File: rtl/axi_bram_log_reader_if.sv
// -----------------------------------------------------------------------------
// axi_bram_log_reader_if
// Bundles the control, BRAM read port and output stream of the log reader.
//   Control : Start_SI, NumEntries_DI, Abort_SI -> Busy_SO, Done_SO
//   BRAM    : BramEn_SO, BramAddr_SO -> BramRdData_DI
//   Stream  : OutValid_SO, OutData_DO, OutLast_SO <- OutReady_SI
// slave  : the reader itself
// master : whoever drives control, models the BRAM and sinks the stream
// -----------------------------------------------------------------------------
interface axi_bram_log_reader_if
    import axi_log_pkg::*;
#(
    parameter int IDX_BITW          = 15,
    parameter int LOGGING_DATA_BITW = 96,
    parameter int OUT_DATA_BITW     = 32
);

    logic                         Start_SI;
    logic [IDX_BITW-1:0]          NumEntries_DI;
    logic                         Abort_SI;
    logic                         Busy_SO;
    logic                         Done_SO;
    logic                         BramEn_SO;
    logic [IDX_BITW:0]            BramAddr_SO;
    logic [LOGGING_DATA_BITW-1:0] BramRdData_DI;
    logic                         OutValid_SO;
    logic                         OutReady_SI;
    logic [OUT_DATA_BITW-1:0]     OutData_DO;
    logic                         OutLast_SO;

    modport slave (
        input  Start_SI, NumEntries_DI, Abort_SI, BramRdData_DI, OutReady_SI,
        output Busy_SO, Done_SO, BramEn_SO, BramAddr_SO,
               OutValid_SO, OutData_DO, OutLast_SO
    );

    modport master (
        output Start_SI, NumEntries_DI, Abort_SI, BramRdData_DI, OutReady_SI,
        input  Busy_SO, Done_SO, BramEn_SO, BramAddr_SO,
               OutValid_SO, OutData_DO, OutLast_SO
    );

endinterface

// File: rtl/axi_bram_log_reader_serializer.sv
// -----------------------------------------------------------------------------
// log_entry_serializer
// Holds one captured log record and emits it as three stream words
// (id/len, address, timestamp) on a valid/ready interface.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   capture_i       : load rd_data_i into the entry register, restart at word 0
//   rd_data_i       : record read from the BRAM
//   send_i          : parent FSM is in its send state (drives valid)
//   last_entry_i    : the held record is the final one of the drain
//   ready_i         : downstream ready
//   valid_o/data_o/last_o : stream outputs
//   entry_done_o    : final word of the held record transfers this cycle
// -----------------------------------------------------------------------------
module log_entry_serializer
    import axi_log_pkg::*;
#(
    parameter int LOGGING_DATA_BITW = 96,
    parameter int OUT_DATA_BITW     = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         capture_i,
    input  logic [LOGGING_DATA_BITW-1:0] rd_data_i,
    input  logic                         send_i,
    input  logic                         last_entry_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [OUT_DATA_BITW-1:0]     data_o,
    output logic                         last_o,
    output logic                         entry_done_o
);

    logic [LOGGING_DATA_BITW-1:0] entry_q, entry_d;
    logic [1:0]                   word_q, word_d;
    logic                         hs;
    logic                         last_word;

    assign hs        = send_i & ready_i;
    assign last_word = (word_q == 2'(LOG_WORDS_PER_ENTRY - 1));

    always_comb begin
        entry_d = entry_q;
        word_d  = word_q;
        if (capture_i) begin
            entry_d = rd_data_i;
            word_d  = 2'd0;
        end else if (hs) begin
            word_d = last_word ? 2'd0 : word_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q <= '0;
            word_q  <= 2'd0;
        end else begin
            entry_q <= entry_d;
            word_q  <= word_d;
        end
    end

    // Data, valid and last come only from registers and the parent state,
    // so they hold steady while the sink stalls.
    always_comb begin
        data_o = '0;
        if (send_i) begin
            case (word_q)
                2'd0:    data_o = entry_q[ID_LOW   +: OUT_DATA_BITW];
                2'd1:    data_o = entry_q[ADDR_LOW +: OUT_DATA_BITW];
                2'd2:    data_o = entry_q[TS_LOW   +: OUT_DATA_BITW];
                default: data_o = '0;
            endcase
        end
    end

    assign valid_o      = send_i;
    assign last_o       = send_i & last_word & last_entry_i;
    assign entry_done_o = hs & last_word;

endmodule

// File: rtl/axi_bram_log_reader.sv
// -----------------------------------------------------------------------------
// axi_bram_log_reader
// Drains entries 0..N-1 of the logging BRAM (N clamped to capacity), reading
// one 96-bit record at a time and streaming it as three 32-bit words.
//   Clk_CI  : clock
//   Rst_RI  : asynchronous active-high reset
//   bus_io  : control (Start/NumEntries/Abort/Busy/Done), BRAM read port
//             (BramEn/BramAddr/BramRdData) and output stream
//             (OutValid/OutReady/OutData/OutLast)
// -----------------------------------------------------------------------------
module axi_bram_log_reader
    import axi_log_pkg::*;
#(
    parameter int LOGGING_DATA_BITW = 96,
    parameter int OUT_DATA_BITW     = 32,
    parameter int NUM_SER_BRAMS     = 12,
    parameter int BRAM_RD_LAT       = 1,
    parameter int IDX_BITW          = $clog2(1024 * NUM_SER_BRAMS) + 1
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    axi_bram_log_reader_if.slave  bus_io
);

    localparam int                 CAP   = log_cap(NUM_SER_BRAMS);
    localparam logic [IDX_BITW-1:0] CAP_L = IDX_BITW'(CAP);

    state_e              state_q, state_d;
    logic [IDX_BITW-1:0] idx_q, idx_d;
    logic [IDX_BITW-1:0] ncl_q, ncl_d;
    logic                wait_q, wait_d;
    logic                capture;
    logic                entry_done;
    logic                last_entry;
    logic [IDX_BITW-1:0] idx_inc;
    logic [IDX_BITW-1:0] num_clamped;

    assign idx_inc     = idx_q + IDX_BITW'(1);
    assign num_clamped = (bus_io.NumEntries_DI > CAP_L) ? CAP_L : bus_io.NumEntries_DI;
    // idx == Ncl-1, written without the subtraction
    assign last_entry  = (idx_inc == ncl_q);

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ncl_q   <= '0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ncl_q   <= ncl_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ncl_d   = ncl_q;
        wait_d  = wait_q;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_io.Start_SI && !bus_io.Abort_SI) begin
                    ncl_d   = num_clamped;
                    idx_d   = '0;
                    state_d = (num_clamped == '0) ? DONE : RD;
                end
            end
            RD: begin
                wait_d  = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                // wait_q counts elapsed WAIT cycles; data is valid in the last one
                if (wait_q == 1'(BRAM_RD_LAT - 1)) begin
                    capture = 1'b1;
                    state_d = SEND;
                end else begin
                    wait_d = 1'b1;
                end
            end
            SEND: begin
                if (entry_done) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc < ncl_q) ? RD : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every transition; a same-cycle handshake has
        // already been counted by the serializer.
        if (bus_io.Abort_SI && (state_q != IDLE)) begin
            state_d = IDLE;
            capture = 1'b0;
        end
    end

    assign bus_io.Busy_SO     = (state_q != IDLE);
    assign bus_io.Done_SO     = (state_q == DONE);
    assign bus_io.BramEn_SO   = (state_q == RD);
    // idx never exceeds CAP-1, so its MSB is always zero and can be dropped
    assign bus_io.BramAddr_SO = (state_q == RD) ? {idx_q[IDX_BITW-2:0], 2'b00} : '0;

    log_entry_serializer #(
        .LOGGING_DATA_BITW (LOGGING_DATA_BITW),
        .OUT_DATA_BITW     (OUT_DATA_BITW)
    ) u_ser (
        .clk_i        (Clk_CI),
        .rst_i        (Rst_RI),
        .capture_i    (capture),
        .rd_data_i    (bus_io.BramRdData_DI),
        .send_i       (state_q == SEND),
        .last_entry_i (last_entry),
        .ready_i      (bus_io.OutReady_SI),
        .valid_o      (bus_io.OutValid_SO),
        .data_o       (bus_io.OutData_DO),
        .last_o       (bus_io.OutLast_SO),
        .entry_done_o (entry_done)
    );

endmodule
